// File: rtl/rl_ram_1rw_ctrl.sv
// rl_ram_1rw_ctrl: round-robin write/read arbiter for a 1RW RAM with a
// 3-entry read response FIFO and valid/ready backpressure.
module rl_ram_1rw_ctrl #(
    parameter int ABITS = 10,
    parameter int DBITS = 32,
    localparam int BBITS = (DBITS + 7) / 8
) (
    input  logic             rstn,
    input  logic             clk,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [ABITS-1:0] wr_addr,
    input  logic [BBITS-1:0] wr_be,
    input  logic [DBITS-1:0] wr_data,
    input  logic             rd_valid,
    output logic             rd_ready,
    input  logic [ABITS-1:0] rd_addr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DBITS-1:0] rsp_data,
    output logic [ABITS-1:0] ram_addr,
    output logic             ram_we,
    output logic [BBITS-1:0] ram_be,
    output logic [DBITS-1:0] ram_din,
    input  logic [DBITS-1:0] ram_dout
);

    logic [1:0]       cnt_q, cnt_d, head_q, head_d, tail_q, tail_d;
    logic             infl_q, infl_d, pri_q, pri_d;
    logic [DBITS-1:0] buf_q [3];
    logic [DBITS-1:0] buf_d [3];
    logic             rd_elig, gnt_w, gnt_r, push, pop;

    // pri_q: 0 = write wins contention, 1 = read wins
    always_comb begin
        rd_elig = rd_valid && (({1'b0, cnt_q} + {2'b0, infl_q}) < 3'd3);
        gnt_w   = rstn && wr_valid && (!rd_elig || !pri_q);
        gnt_r   = rstn && rd_elig && (!wr_valid || pri_q);
        pri_d   = (wr_valid && rd_elig) ? gnt_w : pri_q;
        infl_d  = gnt_r;
        push    = infl_q;
        pop     = rsp_valid && rsp_ready;
        cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};
        head_d  = pop ? ((head_q == 2'd2) ? 2'd0 : head_q + 2'd1) : head_q;
        tail_d  = push ? ((tail_q == 2'd2) ? 2'd0 : tail_q + 2'd1) : tail_q;
        buf_d   = buf_q;
        if (push)
            buf_d[tail_q] = ram_dout;
    end

    assign wr_ready  = gnt_w;
    assign rd_ready  = gnt_r;
    assign rsp_valid = cnt_q != 2'd0;
    assign rsp_data  = buf_q[head_q];
    assign ram_we    = gnt_w;
    assign ram_addr  = gnt_w ? wr_addr : rd_addr;
    assign ram_be    = gnt_w ? wr_be : '0;
    assign ram_din   = gnt_w ? wr_data : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            infl_q <= 1'b0;
            pri_q  <= 1'b0;
            buf_q  <= '{default: '0};
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
            infl_q <= infl_d;
            pri_q  <= pri_d;
            buf_q  <= buf_d;
        end
    end

    assert property (@(posedge clk) disable iff (!rstn) !(push && cnt_q == 2'd3));

endmodule

// File: tb/tb_rl_ram_1rw_ctrl.sv
// tb_rl_ram_1rw_ctrl: directed bench with a byte-enabled RAM model;
// inputs driven and outputs sampled around the falling clock edge.
module tb_rl_ram_1rw_ctrl;

    logic        rstn, clk;
    logic        wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid, rsp_ready, ram_we;
    logic [9:0]  wr_addr, rd_addr, ram_addr;
    logic [3:0]  wr_be, ram_be;
    logic [31:0] wr_data, rsp_data, ram_din, ram_dout;
    logic [31:0] mem [0:1023];
    int          checks = 0;
    int          failures = 0;

    rl_ram_1rw_ctrl #(.ABITS(10), .DBITS(32)) dut (
        .rstn(rstn), .clk(clk),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we)
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        ram_dout <= mem[ram_addr];
    end

    task automatic do_reset();
        rstn = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_write(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; wr_valid = 1'b1; wr_addr = 10'd3; wr_be = 4'hF; wr_data = 32'h1;
        rd_valid = 1'b1; rd_addr = 10'd3; rsp_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
        checks++; if (wr_ready !== 1'b0 || rd_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b%b exp=00", wr_ready, rd_ready); end
        wr_valid = 1'b0; rd_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        wr_valid = 1'b1; wr_addr = 10'h005; wr_be = 4'hF; wr_data = 32'hAABBCCDD; #1;
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL basic_wr_ready got=%b exp=1", wr_ready); end
        checks++; if ({ram_we, ram_addr, ram_be, ram_din} !== {1'b1, 10'h005, 4'hF, 32'hAABBCCDD}) begin failures++; $display("FAIL basic_ram_write got=%b/%h/%h/%h exp=1/005/f/aabbccdd", ram_we, ram_addr, ram_be, ram_din); end
        @(negedge clk);
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 10'h005; #1;
        checks++; if (rd_ready !== 1'b1) begin failures++; $display("FAIL basic_rd_ready got=%b exp=1", rd_ready); end
        checks++; if ({ram_we, ram_addr, ram_be, ram_din} !== {1'b0, 10'h005, 4'h0, 32'h0}) begin failures++; $display("FAIL basic_ram_read got=%b/%h/%h/%h exp=0/005/0/0", ram_we, ram_addr, ram_be, ram_din); end
        @(negedge clk);
        rd_valid = 1'b0; #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL basic_lat1 got=%b exp=0", rsp_valid); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hAABBCCDD) begin failures++; $display("FAIL basic_rsp got=%b/%h exp=1/aabbccdd", rsp_valid, rsp_data); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL basic_popped got=%b exp=0", rsp_valid); end
        @(negedge clk);
    endtask

    task automatic test_partial();
        wr_valid = 1'b1; wr_addr = 10'h005; wr_be = 4'b0100; wr_data = 32'h11223344; #1;
        checks++; if (ram_be !== 4'b0100) begin failures++; $display("FAIL partial_be got=%h exp=4", ram_be); end
        @(negedge clk);
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 10'h005; #1;
        checks++; if (rd_ready !== 1'b1) begin failures++; $display("FAIL partial_rd_ready got=%b exp=1", rd_ready); end
        @(negedge clk);
        rd_valid = 1'b0;
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hAA22CCDD) begin failures++; $display("FAIL partial_rsp got=%b/%h exp=1/aa22ccdd", rsp_valid, rsp_data); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) do_write(10'(i), 4'hF, 32'(i * 3));
        for (int j = 0; j < 10; j++) begin
            rd_valid = (j < 8); rd_addr = 10'(j); #1;
            if (j < 8) begin
                checks++; if (rd_ready !== 1'b1) begin failures++; $display("FAIL b2b_rd_ready[%0d] got=%b exp=1", j, rd_ready); end
            end
            if (j >= 2) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'((j - 2) * 3)) begin failures++; $display("FAIL b2b_rsp[%0d] got=%b/%0d exp=1/%0d", j - 2, rsp_valid, rsp_data, (j - 2) * 3); end
            end
            @(negedge clk);
        end
        rd_valid = 1'b0; #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", rsp_valid); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [7:0]  rdy_v = 8'b0100_0111;
        logic [31:0] dat_v [4] = '{32'h100, 32'h100, 32'h101, 32'h101};
        int acc = 0;
        for (int i = 0; i < 4; i++) do_write(10'(8 + i), 4'hF, 32'h100 + 32'(i));
        for (int j = 0; j < 8; j++) begin
            rd_valid = 1'b1; rd_addr = 10'(8 + acc); rsp_ready = (j == 5); #1;
            checks++; if (rd_ready !== rdy_v[j]) begin failures++; $display("FAIL bp_rd_ready[%0d] got=%b exp=%b", j, rd_ready, rdy_v[j]); end
            if (rdy_v[j]) acc++;
            if (j >= 4) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_data !== dat_v[j - 4]) begin failures++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/%h", j, rsp_valid, rsp_data, dat_v[j - 4]); end
            end
            @(negedge clk);
        end
        rd_valid = 1'b0; rsp_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            if (j < 3) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h101 + 32'(j)) begin failures++; $display("FAIL bp_drain[%0d] got=%b/%h exp=1/%h", j, rsp_valid, rsp_data, 32'h101 + 32'(j)); end
            end else begin
                checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", rsp_valid); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_arbitration();
        logic [6:0] wexp = 7'b011_1000;
        logic [6:0] rexp = 7'b100_0111;
        do_reset();
        wr_valid = 1'b1; wr_addr = 10'd30; wr_be = 4'hF; rd_valid = 1'b1; rd_addr = 10'd31;
        for (int j = 0; j < 5; j++) begin
            wr_data = 32'(j); #1;
            checks++; if (wr_ready !== (j % 2 == 0) || rd_ready !== (j % 2 == 1)) begin failures++; $display("FAIL arb_alt[%0d] got=w%b r%b exp=w%b r%b", j, wr_ready, rd_ready, j % 2 == 0, j % 2 == 1); end
            @(negedge clk);
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        repeat (4) @(negedge clk);
        for (int j = 0; j < 7; j++) begin
            rd_valid = 1'b1; wr_valid = (j >= 3); rsp_ready = (j == 5); #1;
            checks++; if (wr_ready !== wexp[j] || rd_ready !== rexp[j]) begin failures++; $display("FAIL arb_full[%0d] got=w%b r%b exp=w%b r%b", j, wr_ready, rd_ready, wexp[j], rexp[j]); end
            @(negedge clk);
        end
        wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 10'h005;
        repeat (3) @(negedge clk);
        rd_valid = 1'b0; #1;
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL mid_pre got=%b exp=1", rsp_valid); end
        rstn = 1'b0; wr_valid = 1'b1; wr_addr = 10'd40; wr_be = 4'hF; wr_data = 32'hDEAD; #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_async_drop got=%b exp=0", rsp_valid); end
        checks++; if (ram_we !== 1'b0 || wr_ready !== 1'b0) begin failures++; $display("FAIL mid_no_write got=%b%b exp=00", ram_we, wr_ready); end
        @(negedge clk);
        wr_valid = 1'b0; rstn = 1'b1; rsp_ready = 1'b1; #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_released got=%b exp=0", rsp_valid); end
        @(negedge clk);
        rd_valid = 1'b1; rd_addr = 10'd7; #1;
        checks++; if (rd_ready !== 1'b1) begin failures++; $display("FAIL mid_rd_ready got=%b exp=1", rd_ready); end
        @(negedge clk);
        rd_valid = 1'b0; #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_no_stale got=%b exp=0", rsp_valid); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd21) begin failures++; $display("FAIL mid_rsp got=%b/%0d exp=1/21", rsp_valid, rsp_data); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_single got=%b exp=0", rsp_valid); end
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
        wr_addr = '0; wr_be = '0; wr_data = '0; rd_addr = '0;
        test_reset();
        test_basic();
        test_partial();
        test_back_to_back();
        test_backpressure();
        test_arbitration();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
